// File: rtl/snn_input_loader.sv
// Receives one packed 28x28 binary image as a byte stream, unpacks it LSB-first
// into a 784x1 bit memory, pulses start to snn_core and serves its bit reads.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for the next byte of the current image
// UNPACK    | shifting one byte into memory, one bit per cycle (8 cycles)
// FIRE      | image complete, one-cycle start pulse to the core
// WAIT_DONE | core running on the image, incoming bytes are dropped
module snn_input_loader #(
    parameter int IMG_BITS  = 784,
    parameter int IMG_BYTES = IMG_BITS / 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       done,
    output logic       busy,
    output logic       ovr_err,
    input  logic       clr_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        UNPACK    = 2'd1,
        FIRE      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [6:0] LAST_BYTE  = 7'(IMG_BYTES - 1);
    localparam logic [9:0] ADDR_LIMIT = 10'(IMG_BITS);

    state_t      state_q, state_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  pending_q, pending_d;
    logic        pending_vld_q, pending_vld_d;
    logic        start_q, start_d;
    logic        busy_q, busy_d;
    logic        q_input_q, q_input_d;
    logic        ovr_err_q, ovr_err_d;

    logic        mem_q [IMG_BITS];
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic        last_bit;
    logic [7:0]  ahead;
    logic        rx_take;
    logic        rx_drop;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        rx_take       = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = {byte_cnt_q, 3'b000} + {7'd0, bit_cnt_q};
        last_bit      = (bit_cnt_q == 3'd7);
        // index of the byte an arriving rx_data would become, minus one
        ahead         = {1'b0, byte_cnt_q} + {7'd0, pending_vld_q};

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    rx_take   = 1'b1;
                    shift_d   = rx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = UNPACK;
                end
            end
            UNPACK: begin
                wr_en     = 1'b1;
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                // on the last bit the current byte retires, so a slot frees up
                rx_take   = rx_rdy && (!pending_vld_q || last_bit)
                            && (ahead < {1'b0, LAST_BYTE});
                if (last_bit) begin
                    byte_cnt_d = byte_cnt_q + 7'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = FIRE;
                    end else if (pending_vld_q) begin
                        shift_d       = pending_q;
                        pending_vld_d = rx_take;
                        if (rx_take) begin
                            pending_d = rx_data;
                        end
                    end else if (rx_take) begin
                        shift_d = rx_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_take) begin
                    pending_d     = rx_data;
                    pending_vld_d = 1'b1;
                end
            end
            FIRE: begin
                byte_cnt_d = 7'd0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_drop = rx_rdy && !rx_take;
        if (rx_drop) begin
            ovr_err_d = 1'b1;
        end else if (clr_err) begin
            ovr_err_d = 1'b0;
        end else begin
            ovr_err_d = ovr_err_q;
        end

        start_d   = (state_d == FIRE);
        busy_d    = (state_d != IDLE) || (byte_cnt_d != 7'd0);
        q_input_d = (addr_input_unit < ADDR_LIMIT) ? mem_q[addr_input_unit] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 7'd0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            pending_q     <= 8'd0;
            pending_vld_q <= 1'b0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            q_input_q     <= 1'b0;
            ovr_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            q_input_q     <= q_input_d;
            ovr_err_q     <= ovr_err_d;
        end
    end

    // image memory is deliberately not reset; contents are stale until rewritten
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= shift_q[0];
        end
    end

    assign q_input = q_input_q;
    assign start   = start_q;
    assign busy    = busy_q;
    assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Bench for snn_input_loader: directed sequences plus a random byte stream,
// checked against a queue-based model of a two-slot, 8-cycles-per-byte loader.
module tb_snn_input_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [9:0] addr_input_unit;
    logic       q_input;
    logic       start;
    logic       done;
    logic       busy;
    logic       ovr_err;
    logic       clr_err;

    always #5 clk = ~clk;

    snn_input_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_rdy          (rx_rdy),
        .rx_data         (rx_data),
        .addr_input_unit (addr_input_unit),
        .q_input         (q_input),
        .start           (start),
        .done            (done),
        .busy            (busy),
        .ovr_err         (ovr_err),
        .clr_err         (clr_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: accepted bytes of the current image and the edge at
    // which each finishes unpacking (each byte occupies 8 edges, 2 in flight max)
    int  img_cnt;
    int  q_fin[$];
    int  fire_edge;
    bit  m_ovr;
    bit  exp_start;
    bit  exp_busy;
    bit  exp_q;
    bit  exp_q_chk;
    bit  mem_m [784];
    bit  known [784];

    int  starts_seen = 0;
    int  start_edge  = 0;
    int  rx_edge     = 0;

    typedef struct {
        logic [9:0] addr;
        logic       exp_q;
    } rd_vec_t;

    rd_vec_t rd_a5 [12];
    rd_vec_t rd_small [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        img_cnt   = 0;
        q_fin.delete();
        fire_edge = -100;
        m_ovr     = 1'b0;
        exp_start = 1'b0;
        exp_busy  = 1'b0;
        foreach (known[i]) known[i] = 1'b0;
    endfunction

    function automatic void model_edge(input logic rx, input logic [7:0] d, input logic dn,
                                       input logic clr, input logic [9:0] a);
        int t;
        int fin;
        bit drop;
        bit waiting;
        bit settled;
        t       = cyc;
        drop    = 1'b0;
        waiting = (img_cnt == 98);
        settled = 1'b1;
        foreach (q_fin[i]) if (q_fin[i] >= t) settled = 1'b0;
        exp_q_chk = 1'b0;
        exp_q     = 1'b0;
        if (a >= 10'd784) begin
            exp_q_chk = 1'b1;
        end else if (settled && known[a]) begin
            exp_q_chk = 1'b1;
            exp_q     = mem_m[a];
        end
        if (rx) begin
            while (q_fin.size() > 0 && q_fin[0] <= t) void'(q_fin.pop_front());
            if (waiting || q_fin.size() >= 2) begin
                drop = 1'b1;
            end else begin
                fin = (q_fin.size() == 0) ? t + 8 : q_fin[$] + 8;
                q_fin.push_back(fin);
                for (int j = 0; j < 8; j++) begin
                    mem_m[img_cnt*8 + j] = d[j];
                    known[img_cnt*8 + j] = 1'b1;
                end
                img_cnt++;
                if (img_cnt == 98) fire_edge = fin;
            end
        end
        if (waiting && dn && t >= fire_edge + 2) img_cnt = 0;
        exp_start = (img_cnt == 98) && (t == fire_edge);
        exp_busy  = (img_cnt != 0);
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endfunction

    task automatic tick(input logic rx, input logic [7:0] d, input logic dn,
                        input logic clr, input logic [9:0] a);
        rx_rdy          = rx;
        rx_data         = d;
        done            = dn;
        clr_err         = clr;
        addr_input_unit = a;
        @(posedge clk);
        cyc++;
        model_edge(rx, d, dn, clr, a);
        @(negedge clk);
        chk("start", start, exp_start);
        chk("busy", busy, exp_busy);
        chk("ovr_err", ovr_err, m_ovr);
        if (exp_q_chk) chk($sformatf("q_input@%0d", a), q_input, exp_q);
        if (start === 1'b1) begin
            starts_seen++;
            start_edge = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        tick(1'b1, d, 1'b0, 1'b0, 10'd0);
        rx_edge = cyc;
        idle(gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_rdy  = (i % 2 == 0);
            rx_data = 8'($urandom);
            @(posedge clk);
            cyc++;
            @(negedge clk);
            chk("rst_start", start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_q_input", q_input, 0);
            chk("rst_ovr_err", ovr_err, 0);
        end
        rx_rdy = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        idle(2);
    endtask

    int starts0;
    int nz;

    initial begin
        rd_a5[0]  = '{10'd0,    1'b1};
        rd_a5[1]  = '{10'd1,    1'b0};
        rd_a5[2]  = '{10'd2,    1'b1};
        rd_a5[3]  = '{10'd3,    1'b0};
        rd_a5[4]  = '{10'd5,    1'b1};
        rd_a5[5]  = '{10'd7,    1'b1};
        rd_a5[6]  = '{10'd8,    1'b1};
        rd_a5[7]  = '{10'd782,  1'b0};
        rd_a5[8]  = '{10'd783,  1'b1};
        rd_a5[9]  = '{10'd784,  1'b0};
        rd_a5[10] = '{10'd800,  1'b0};
        rd_a5[11] = '{10'd1023, 1'b0};
        for (int i = 0; i < 16; i++) begin
            rd_small[i].addr  = 10'(i);
            rd_small[i].exp_q = (i == 0 || i == 9);
        end

        rst_n           = 1'b0;
        rx_rdy          = 1'b0;
        rx_data         = 8'h00;
        done            = 1'b0;
        clr_err         = 1'b0;
        addr_input_unit = 10'd0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("idle_after_reset_busy", busy, 0);

        // full image of 0xA5, bytes 20 cycles apart
        starts0 = starts_seen;
        for (int k = 0; k < 98; k++) send(8'hA5, 19);
        chk("a5_start_count", starts_seen - starts0, 1);
        chk("a5_start_latency", start_edge - rx_edge, 8);
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, rd_a5[i].addr);
            chk($sformatf("a5_read_%0d", rd_a5[i].addr), q_input, rd_a5[i].exp_q);
        end

        // byte while the core is running is dropped
        tick(1'b1, 8'hFF, 1'b0, 1'b0, 10'd0);
        chk("wait_drop_ovr", ovr_err, 1);
        chk("wait_drop_busy", busy, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 10'd0);
        chk("wait_drop_addr0", q_input, 1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 10'd0);
        chk("done_busy", busy, 0);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 10'd0);
        chk("clr_ovr", ovr_err, 0);

        // back-to-back bytes: first unpacks, second pends, third drops
        tick(1'b1, 8'h01, 1'b0, 1'b0, 10'd0);
        tick(1'b1, 8'h02, 1'b0, 1'b0, 10'd0);
        tick(1'b1, 8'h03, 1'b0, 1'b0, 10'd0);
        chk("burst_ovr", ovr_err, 1);
        idle(20);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, rd_small[i].addr);
            chk($sformatf("burst_read_%0d", rd_small[i].addr), q_input, rd_small[i].exp_q);
        end
        chk("burst_busy", busy, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, 10'd0);

        // reset after 50 bytes, then a fresh all-zero image
        for (int k = 2; k < 50; k++) send(8'($urandom), 9);
        do_reset();
        starts0 = starts_seen;
        for (int k = 0; k < 98; k++) send(8'h00, 9);
        idle(5);
        chk("zero_start_count", starts_seen - starts0, 1);
        nz = 0;
        for (int a = 0; a < 784; a++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 10'(a));
            if (q_input !== 1'b0) nz++;
        end
        chk("zero_img_set_bits", nz, 0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 10'd0);
        chk("zero_done_busy", busy, 0);

        // 99th byte while byte 97 is still unpacking
        starts0 = starts_seen;
        for (int k = 0; k < 97; k++) send(8'($urandom), 9);
        send(8'($urandom), 2);
        tick(1'b1, 8'($urandom), 1'b0, 1'b0, 10'd800);
        chk("extra_byte_ovr", ovr_err, 1);
        idle(15);
        chk("extra_byte_start_count", starts_seen - starts0, 1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 10'd800);
        chk("addr800", q_input, 0);
        tick(1'b0, 8'h00, 1'b1, 1'b1, 10'd0);
        chk("extra_clr_ovr", ovr_err, 0);

        // random stream against the model
        for (int i = 0; i < 6000; i++) begin
            tick(($urandom % 5) == 0, 8'($urandom), ($urandom % 40) == 0,
                 ($urandom % 60) == 0, 10'($urandom % 800));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/snn_input_loader.md
Name: snn_input_loader

Overview:
- Upstream stage of snn_core. Takes the serial-receiver byte stream carrying one 28x28 binary image (98 bytes, 784 bits).
- Unpacks each byte into a 784x1 input-unit memory, then pulses start to the core.
- Serves the core's reads (addr_input_unit -> q_input) and holds off new images until the core signals done.
- Sits between the UART receiver and snn_core.

Parameters:
IMG_BITS, 784, number of input units (bits per image)
IMG_BYTES, 98, bytes per image (IMG_BITS/8)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
rx_rdy  input  1  one-cycle pulse: rx_data holds a new received byte
rx_data  input  8  received byte
addr_input_unit  input  10  read address from snn_core
q_input  output  1  registered input-unit bit for addr_input_unit
start  output  1  one-cycle pulse: image complete, core may run
done  input  1  core finished (pulse)
busy  output  1  load or inference in progress
ovr_err  output  1  sticky: a byte was dropped
clr_err  input  1  synchronous clear of ovr_err

Behaviour:
- Reset: clk and rst_n as decided. The following reset to 0: state=IDLE, byte_cnt, bit_cnt, pending_vld, start, busy, q_input, ovr_err. Memory contents are not cleared; they are stale after reset.
- Bit mapping: byte k (0..97), bit j (LSB first) is written to address 8k+j.
- Read port:
  - q_input <= mem[addr_input_unit] every cycle, in all states. Latency is 1 cycle.
  - Addresses >= IMG_BITS return 0.
  - In the same cycle as a write to the same address, the read returns the old value.
- States: IDLE, UNPACK, FIRE, WAIT_DONE.
- IDLE:
  - On rx_rdy: latch rx_data into shift_reg, bit_cnt=0, go to UNPACK.
  - busy=1 when byte_cnt!=0.
- UNPACK:
  - Each cycle: write shift_reg[0] to address {byte_cnt,3'b0}+bit_cnt, shift right, bit_cnt++. Exactly 8 cycles.
  - On the bit_cnt==7 cycle: byte_cnt++.
    - If the old byte_cnt was 97: go to FIRE.
    - Else if pending_vld: load the pending byte, clear pending_vld, stay in UNPACK with bit_cnt=0.
    - Else go to IDLE.
  - rx_rdy during UNPACK:
    - Stored in the 1-entry pending register if !pending_vld and byte_cnt<97.
    - Otherwise dropped and ovr_err=1.
  - If rx_rdy coincides with the pending register being consumed, the new byte occupies the freed pending slot.
- FIRE: start=1 for exactly one cycle, byte_cnt=0, go to WAIT_DONE. busy=1.
- WAIT_DONE:
  - busy=1. Any rx_rdy is dropped and sets ovr_err.
  - On done go to IDLE. Memory is not cleared.
  - done in any other state is ignored.
- ovr_err:
  - Set by any dropped byte.
  - Cleared by clr_err. Set wins if both occur in the same cycle.
- Start latency: rx_rdy of byte 97 seen in IDLE at cycle T gives writes in T+1..T+8 and start=1 in T+9.
- Mid-operation reset: state returns to IDLE with counts 0. The next 98 bytes form a fresh image.
- Counters:
  - byte_cnt is 7 bits; bit_cnt is 3 bits and wraps 7->0.
  - byte_cnt never exceeds 97 in IDLE/UNPACK.

Test Plan:
- Reset held 3 cycles, rx_rdy toggling -> start=0, busy=0, q_input=0, ovr_err=0, no transition out of IDLE.
- 98 bytes of 0xA5, spaced 20 cycles apart:
  - start high exactly once, 9 cycles after the last rx_rdy.
  - Reads after that: addr0 -> 1, addr1 -> 0, addr2 -> 1, addr7 -> 1, addr783 -> 1, each 1 cycle after the address is applied.
- Bytes 0x01, 0x02, 0x03 on three consecutive cycles:
  - 0x01 unpacked, 0x02 pending, 0x03 dropped, ovr_err=1.
  - Then addr0=1, addr9=1, all other addresses 0..15 = 0.
- After start, byte 0xFF sent before done -> ovr_err=1, busy=1, addr0 unchanged. Then done pulse -> busy=0. Then clr_err -> ovr_err=0.
- rst_n asserted after 50 bytes, then 98 bytes of 0x00 -> single start pulse after the 98th byte, and addr 0..783 all read 0.
- addr_input_unit=800 -> q_input=0. A 99th byte arriving while byte 97 is unpacking -> dropped, ovr_err=1, single start pulse.
